lcd_frame_buffer: RTL
=====================

Name: lcd_frame_buffer

Overview:
- Parametrised successor to the LCD shift-register/frame-buffer output stage.
- Captures the PPU pixel stream into a 2- or 3-bank frame store and regenerates fixed video timing from a single clock.
- Bank handoff is frame-coherent: incomplete frames are never shown.
- Counts dropped and repeated frames, and substitutes a blank colour while the LCD is off.
- Sits between the PPU pixel output and the video mixer/scaler.

Parameters:
- PIX_W, 15, pixel width in bits (BGR555).
- H_ACT, 160, active pixels per line.
- V_ACT, 144, active lines per frame.
- HTOTAL, 425, output pixels per line.
- VTOTAL, 264, output lines per frame.
- VSTART, 105, first active output line.
- HSTART, 52, first active output pixel.
- DIV, 10, clk_sys cycles per output pixel.
- DIV_LONG, 16, clk_sys cycles for the last pixel of each line.
- BANKS, 3, number of frame banks; only 2 or 3 are legal.
- BLANK, 15'h7FFF, colour output while the LCD is off.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ce  in  1  PPU pixel clock enable.
- pix_valid  in  1  pixel present this ce.
- pix_data  in  PIX_W  pixel value.
- frame_start  in  1  PPU vsync level; its rising edge commits a frame.
- lcd_on  in  1  LCDC enable.
- ce_pix  out  1  output pixel strobe.
- hs  out  1  horizontal sync, active high.
- vs  out  1  vertical sync, active high.
- hbl  out  1  horizontal blank.
- vbl  out  1  vertical blank.
- h_cnt  out  9  output pixel counter.
- v_cnt  out  9  output line counter.
- pix_out  out  PIX_W  output pixel.
- drop_cnt  out  8  frames overwritten before display; saturates.
- rep_cnt  out  8  frames shown more than once; saturates.

Behaviour:
- Reset values:
  - All outputs 0, counters 0; hbl=1, vbl=1.
  - wr_bank=0, rd_bank=BANKS-1, no ready frame (ready_valid=0).
- Writer:
  - On ce&pix_valid, if wr_ptr<H_ACT*V_ACT: write pix_data to bank wr_bank at wr_ptr, then wr_ptr++.
  - Writes beyond H_ACT*V_ACT are discarded; wr_ptr holds.
- Commit:
  - Triggered on the rising edge of frame_start (registered edge detect).
  - If wr_ptr==H_ACT*V_ACT:
    - ready_bank<=wr_bank.
    - If ready_valid was already 1, drop_cnt++.
    - ready_valid<=1.
    - New wr_bank:
      - BANKS=3: the bank equal to neither rd_bank nor the new ready_bank.
      - BANKS=2: the other bank (tearing permitted).
  - Otherwise (incomplete frame): no commit, same bank reused.
  - wr_ptr<=0 in both cases.
- Divider:
  - Counts 0..DIV-1.
  - Counts 0..DIV_LONG-1 when h_cnt==HTOTAL-1.
  - ce_pix=1 for one cycle when the divider is 0.
- Counters (advance on ce_pix):
  - h_cnt wraps at HTOTAL-1.
  - v_cnt increments at line end and wraps at VTOTAL-1.
- Sync and blank:
  - hs=1 for h_cnt in [HSTART+H_ACT+103, HSTART+H_ACT+135).
  - vs=1 for v_cnt in [37, 40).
  - hbl=0 for h_cnt in [HSTART, HSTART+H_ACT).
  - vbl=0 for v_cnt in [VSTART, VSTART+V_ACT).
- Read bank latch:
  - Occurs at the end of line VSTART-1.
  - If ready_valid: rd_bank<=ready_bank, ready_valid<=0, rd_ptr<=0.
  - Else: rd_ptr<=0, rd_bank unchanged, rep_cnt++.
- Simultaneous commit and read latch in the same cycle:
  - The reader takes the newly committed bank (forwarded).
  - ready_valid ends 0 and drop_cnt is not incremented.
  - wr_bank avoids the forwarded bank.
- Read path:
  - In the active area, the memory read is issued at ce_pix.
  - pix_out is registered at the next ce_pix (1 output-pixel latency).
  - rd_ptr increments per active pixel.
  - Outside the active area pix_out=0.
- LCD off:
  - While lcd_on=0, pix_out=BLANK in the active area and writes are ignored.
  - The lcd_on rising edge resets wr_ptr to 0.
  - Timing keeps running.
- Reset mid-frame: immediate return to reset values; memory contents are not cleared.

Test Plan:
- Reset, then run 1 line → ce_pix period 10 cycles, last pixel 16; line = 4256 clk_sys cycles; h_cnt wraps 424→0.
- Write frame of 23040 pixels with value = index, pulse frame_start, run one output frame → pix_out sequence 0..23039 in active area, rep_cnt=0.
- Pulse frame_start after only 1000 pixels → no commit; next output frame repeats previous bank; rep_cnt=1.
- Commit two full frames before line VSTART-1 (BANKS=3) → drop_cnt=1; second frame is displayed.
- Commit on the exact cycle of the read latch → displayed bank equals committed bank; drop_cnt unchanged; wr_bank differs from both.
- lcd_on=0 for one frame → active pixels equal 7FFF; deassert reset_n mid-line → hbl=vbl=1 and h_cnt=0 immediately.

Source files
------------

// File: rtl/lcd_frame_buffer.sv
// lcd_frame_buffer: banked PPU frame store with frame-coherent handoff and regenerated LCD timing
module lcd_frame_buffer #(
  parameter int PIX_W    = 15,
  parameter int H_ACT    = 160,
  parameter int V_ACT    = 144,
  parameter int HTOTAL   = 425,
  parameter int VTOTAL   = 264,
  parameter int VSTART   = 105,
  parameter int HSTART   = 52,
  parameter int DIV      = 10,
  parameter int DIV_LONG = 16,
  parameter int BANKS    = 3,
  parameter int HS_BEG   = HSTART + H_ACT + 103,
  parameter int HS_END   = HSTART + H_ACT + 135,
  parameter int VS_BEG   = 37,
  parameter int VS_END   = 40,
  parameter logic [PIX_W-1:0] BLANK = 15'h7FFF
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             ce,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             frame_start,
  input  logic             lcd_on,
  output logic             ce_pix,
  output logic             hs,
  output logic             vs,
  output logic             hbl,
  output logic             vbl,
  output logic [8:0]       h_cnt,
  output logic [8:0]       v_cnt,
  output logic [PIX_W-1:0] pix_out,
  output logic [7:0]       drop_cnt,
  output logic [7:0]       rep_cnt
);
  localparam int NPIX = H_ACT * V_ACT;
  localparam int PW = $clog2(NPIX + 1);
  localparam int AW = $clog2(BANKS * NPIX);
  localparam int DW = $clog2(DIV_LONG > DIV ? DIV_LONG : DIV);
  localparam logic [8:0] H_LAST = 9'(HTOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(VTOTAL - 1);
  localparam logic [8:0] V_PRE = 9'(VSTART - 1);

  logic [DW-1:0] div;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [AW-1:0] wa, ra;
  logic [1:0] wr_bank, rd_bank, ready_bank, nxt_bank;
  logic ready_valid, fs_q, lcd_q, act_q;
  logic h_last, adv, act, fs_edge, lcd_rise, full, commit, latch, we;
  logic [PIX_W-1:0] rd_q;
  logic [PIX_W-1:0] mem [BANKS*NPIX];

  always_comb begin
    h_last = h_cnt == H_LAST;
    adv = div == (h_last ? DW'(DIV_LONG - 1) : DW'(DIV - 1));
    hs = h_cnt >= 9'(HS_BEG) && h_cnt < 9'(HS_END);
    vs = v_cnt >= 9'(VS_BEG) && v_cnt < 9'(VS_END);
    hbl = !(h_cnt >= 9'(HSTART) && h_cnt < 9'(HSTART + H_ACT));
    vbl = !(v_cnt >= 9'(VSTART) && v_cnt < 9'(VSTART + V_ACT));
    act = !hbl && !vbl;
    fs_edge = frame_start && !fs_q;
    lcd_rise = lcd_on && !lcd_q;
    full = wr_ptr == PW'(NPIX);
    commit = fs_edge && full;
    latch = adv && h_last && v_cnt == V_PRE;
    we = ce && pix_valid && lcd_on && !full && !fs_edge && !lcd_rise;
    // with three banks the writer always takes the one bank nobody else holds
    nxt_bank = BANKS == 2 ? wr_bank ^ 2'd1 : 2'd3 - rd_bank - wr_bank;
    wa = AW'(wr_bank) * AW'(NPIX) + AW'(wr_ptr);
    ra = AW'(rd_bank) * AW'(NPIX) + AW'(rd_ptr);
  end

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      div <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
      ce_pix <= 1'b0;
    end else begin
      ce_pix <= adv;
      div <= adv ? '0 : div + 1'b1;
      if (adv) h_cnt <= h_last ? '0 : h_cnt + 1'b1;
      if (adv && h_last) v_cnt <= v_cnt == V_LAST ? '0 : v_cnt + 1'b1;
    end

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      wr_bank <= '0;
      rd_bank <= 2'(BANKS - 1);
      ready_bank <= '0;
      ready_valid <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop_cnt <= '0;
      rep_cnt <= '0;
      fs_q <= 1'b0;
      lcd_q <= 1'b0;
    end else begin
      fs_q <= frame_start;
      lcd_q <= lcd_on;
      if (fs_edge || lcd_rise) wr_ptr <= '0;
      else if (we) wr_ptr <= wr_ptr + 1'b1;
      if (commit) wr_bank <= nxt_bank;
      if (commit && !latch) begin
        ready_bank <= wr_bank;
        ready_valid <= 1'b1;
        if (ready_valid && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
      end
      // a commit landing on the latch cycle is forwarded straight to the reader
      if (latch) begin
        rd_ptr <= '0;
        if (commit) begin
          rd_bank <= wr_bank;
          ready_valid <= 1'b0;
        end else if (ready_valid) begin
          rd_bank <= ready_bank;
          ready_valid <= 1'b0;
        end else if (!(&rep_cnt)) rep_cnt <= rep_cnt + 1'b1;
      end else if (ce_pix && act) rd_ptr <= rd_ptr + 1'b1;
    end

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      act_q <= 1'b0;
      pix_out <= '0;
    end else if (ce_pix) begin
      act_q <= act;
      pix_out <= !act_q ? '0 : lcd_on ? rd_q : BLANK;
    end

  always_ff @(posedge clk_sys) begin
    if (we) mem[wa] <= pix_data;
    if (ce_pix && act) rd_q <= mem[ra];
  end
endmodule
